// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse-train generator and its falling-edge detector bench:
// the phase state enum and the zero-means-one width rule.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pg_state_t;

  // A programmed length of 0 behaves as a 1-cycle phase.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Command/status bundle of the pulse-train generator; master drives commands, slave is the generator.
interface pulse_train_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] num_pulses;
  logic             dout;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, high_len, low_len, num_pulses,
    input  dout, busy, done
  );

  modport slave (
    input  start, abort, high_len, low_len, num_pulses,
    output dout, busy, done
  );
endinterface

// File: rtl/pg_down_counter.sv
// Loadable down-counter with enable and zero flag; load has priority and the count never wraps below 0.
module pg_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse-train transmitter: N pulses of latched high/low widths on dout, with busy and a done strobe.
// All outputs come straight from flops; the phase and pulse counters are separate down-counters.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  pulse_train_gen_if.slave   bus
);

  pg_state_t        state_reg;
  logic             dout_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] high_len_reg;
  logic [CNT_W-1:0] low_len_reg;

  logic             ph_load, ph_en, ph_zero;
  logic             pc_load, pc_en, pc_zero;
  logic [CNT_W-1:0] ph_val, pc_val;
  logic             accept;

  function automatic logic [CNT_W-1:0] width_m1(input logic [CNT_W-1:0] len);
    return CNT_W'(eff_len(32'(len)) - 1);
  endfunction

  assign accept = bus.start && !bus.abort && (bus.num_pulses != '0);

  always_comb begin
    ph_load = 1'b0;
    ph_en   = 1'b0;
    ph_val  = '0;
    pc_load = 1'b0;
    pc_en   = 1'b0;
    pc_val  = bus.num_pulses;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          ph_load = 1'b1;
          ph_val  = width_m1(bus.high_len);
          pc_load = 1'b1;
        end
      end
      HIGH: begin
        // Abort clears both counters so an aborted train leaves no residue.
        if (bus.abort) begin
          ph_load = 1'b1;
          pc_load = 1'b1;
          pc_val  = '0;
        end else if (ph_zero) begin
          ph_load = 1'b1;
          ph_val  = width_m1(low_len_reg);
          pc_en   = 1'b1;
        end else begin
          ph_en = 1'b1;
        end
      end
      LOW: begin
        if (bus.abort) begin
          ph_load = 1'b1;
          pc_load = 1'b1;
          pc_val  = '0;
        end else if (ph_zero) begin
          if (!pc_zero) begin
            ph_load = 1'b1;
            ph_val  = width_m1(high_len_reg);
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pg_down_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .en       (ph_en),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  pg_down_counter #(.CNT_W(CNT_W)) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .en       (pc_en),
    .load_val (pc_val),
    .zero     (pc_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      dout_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      high_len_reg <= '0;
      low_len_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            if (bus.num_pulses != '0) begin
              state_reg    <= HIGH;
              dout_reg     <= 1'b1;
              busy_reg     <= 1'b1;
              high_len_reg <= bus.high_len;
              low_len_reg  <= bus.low_len;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (bus.abort) begin
            state_reg <= IDLE;
            dout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
          end else if (ph_zero) begin
            state_reg <= LOW;
            dout_reg  <= 1'b0;
          end
        end
        LOW: begin
          if (bus.abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (ph_zero) begin
            // The pulse counter was decremented on HIGH->LOW, so zero here means last pulse.
            if (pc_zero) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= HIGH;
              dout_reg  <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          dout_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout = dout_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomized and directed bench for pulse_train_gen against a timeline model of each train
// (start cycle, widths, count) plus a falling-edge counter on dout.
module tb_pulse_train_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pulse_train_gen_if #(.CNT_W(8)) bus ();

  pulse_train_gen #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the running train is fully described by its acceptance cycle and fields.
  bit act   = 0;
  int tk    = 0;
  int th    = 1;
  int tl    = 1;
  int tn    = 0;
  int zdone = -10;
  int cyc   = 0;
  int fall_cnt = 0;
  logic prev_dout = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int eff(input int len);
    return (len == 0) ? 1 : len;
  endfunction

  function automatic bit exp_busy(input int c);
    return act && (c >= tk + 1) && (c <= tk + tn * (th + tl));
  endfunction

  function automatic bit exp_dout(input int c);
    return exp_busy(c) && (((c - tk - 1) % (th + tl)) < th);
  endfunction

  function automatic bit exp_done(input int c);
    return (act && (c == tk + 1 + tn * (th + tl))) || (c == zdone);
  endfunction

  // One clock cycle: check outputs of cycle cyc, drive inputs sampled at its closing edge, advance model.
  task automatic step(input bit s, input bit a, input int h, input int l, input int n);
    bit bnow;
    @(negedge clk);
    if (prev_dout && !bus.dout) fall_cnt++;
    prev_dout = bus.dout;
    check_val("dout", int'(bus.dout), int'(exp_dout(cyc)));
    check_val("busy", int'(bus.busy), int'(exp_busy(cyc)));
    check_val("done", int'(bus.done), int'(exp_done(cyc)));
    if (act && exp_done(cyc) && cyc != zdone)
      check_val("fall_count", fall_cnt, tn);
    $display("cyc=%0d start=%0d abort=%0d h=%0d l=%0d n=%0d | dout=%0d busy=%0d done=%0d",
             cyc, s, a, h, l, n, bus.dout, bus.busy, bus.done);
    bus.start      = s;
    bus.abort      = a;
    bus.high_len   = 8'(h);
    bus.low_len    = 8'(l);
    bus.num_pulses = 8'(n);
    bnow = exp_busy(cyc);
    if (bnow && a) begin
      act = 0;
    end else if (!bnow && s && !a) begin
      if (n != 0) begin
        act = 1; tk = cyc; th = eff(h); tl = eff(l); tn = n; fall_cnt = 0;
      end else begin
        zdone = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  initial begin
    bus.start = 0; bus.abort = 0;
    bus.high_len = '0; bus.low_len = '0; bus.num_pulses = '0;
    #2;
    check_val("rst_dout", int'(bus.dout), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_done", int'(bus.done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    // Basic train H=2 L=3 N=2; fields scrambled afterwards must not matter.
    step(1, 0, 2, 3, 2);
    idle(13);
    // Zero widths act as 1: square wave.
    step(1, 0, 0, 0, 3);
    idle(9);
    // Zero pulse count: immediate done, no activity.
    step(1, 0, 4, 4, 0);
    idle(3);
    // Abort in cycle 4, fresh start in cycle 6.
    step(1, 0, 2, 3, 2);
    idle(3);
    step(0, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 2, 3, 2);
    idle(12);
    // Abort and start together in idle: start dropped.
    step(1, 1, 2, 2, 2);
    idle(3);
    // Back-to-back: restart in the done cycle.
    step(1, 0, 2, 1, 2);
    idle(6);
    step(1, 0, 1, 1, 1);
    idle(5);
    // Start while busy is ignored.
    step(1, 0, 3, 2, 1);
    step(1, 0, 1, 1, 5);
    idle(6);

    // Asynchronous reset while dout is high.
    step(1, 0, 5, 2, 3);
    idle(1);
    #2;
    check_val("pre_rst_dout", int'(bus.dout), 1);
    bus.start = 0; bus.abort = 0;
    rst = 1'b0;
    #1;
    check_val("async_rst_dout", int'(bus.dout), 0);
    check_val("async_rst_busy", int'(bus.busy), 0);
    check_val("async_rst_done", int'(bus.done), 0);
    act = 0; zdone = -10; fall_cnt = 0; prev_dout = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    cyc += 2;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
           $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
